// File: rtl/z16_wb_pkg.sv
// Shared types and constants for the Z16 write-back unit.
// Optional bypass outputs are enabled by defining Z16_WB_BYPASS_EN.
package z16_wb_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
        logic      we;
    } wr_req_t;

    // r0 is hardwired, so it never gets a scoreboard bit.
    function automatic reg_vec_t reg_onehot(input reg_addr_t a);
        reg_vec_t r;
        r = '0;
        if (a != REG_ZERO) begin
            r[a] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/z16_wb_load_queue.sv
// In-order FIFO of destination addresses for loads in flight.
// Part of z16_writeback_unit (optional bypass: Z16_WB_BYPASS_EN).
module z16_wb_load_queue
    import z16_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_push_addr,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [REG_ADDR_W-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    reg_addr_t        mem [2**PTR_W];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (cnt == CNT_FULL);
    assign o_empty = (cnt == '0);
    assign o_head  = mem[rd_ptr];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_addr;
        end
    end

endmodule

// File: rtl/z16_writeback_unit.sv
// Register-file write master: merges ALU and load results, tracks busy regs.
// Define Z16_WB_BYPASS_EN to add commit-stage forwarding outputs.
module z16_writeback_unit
    import z16_wb_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [3:0]  i_alu_rd_addr,
    input  logic [15:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_ld_issue_valid,
    input  logic [3:0]  i_ld_rd_addr,
    output logic        o_ld_issue_ready,
    input  logic        i_ld_resp_valid,
    input  logic [15:0] i_ld_resp_data,
    output logic        o_ld_resp_ready,
    output logic [3:0]  o_rd_addr,
    output logic        o_rd_we,
    output logic [15:0] o_rd_data,
    input  logic [3:0]  i_rs1_addr,
    input  logic [3:0]  i_rs2_addr,
    output logic        o_rs1_busy,
    output logic        o_rs2_busy,
    output logic [15:0] o_busy
`ifdef Z16_WB_BYPASS_EN
    ,
    output logic        o_rs1_fwd,
    output logic        o_rs2_fwd,
    output logic [15:0] o_fwd_data
`endif
);

    wr_req_t   wr_q;
    wr_req_t   wr_d;
    logic      wr_ld_q;
    logic      wr_ld_d;
    reg_vec_t  busy_q;
    reg_vec_t  busy_d;
    reg_vec_t  set_vec;
    reg_vec_t  clr_vec;

    logic      q_full;
    logic      q_empty;
    reg_addr_t q_head;

    logic      commit_hit;
    logic      issue_acc;
    logic      resp_acc;
    logic      alu_acc;

    z16_wb_load_queue #(
        .DEPTH (LD_DEPTH)
    ) u_ldq (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (issue_acc),
        .i_push_addr (i_ld_rd_addr),
        .i_pop       (resp_acc),
        .o_full      (q_full),
        .o_empty     (q_empty),
        .o_head      (q_head)
    );

    // A new load must not target a register whose write is landing now.
    assign commit_hit = wr_q.we && (wr_q.addr == i_ld_rd_addr);

    assign o_ld_issue_ready = !i_rst && !q_full
                            && !busy_q[i_ld_rd_addr] && !commit_hit;
    assign o_ld_resp_ready  = !i_rst && !q_empty;

    assign issue_acc = i_ld_issue_valid && o_ld_issue_ready;
    assign resp_acc  = i_ld_resp_valid && o_ld_resp_ready;

    // Busy check keeps an ALU write from overtaking an older load (WAW).
    assign o_alu_ready = !i_rst && !resp_acc && !busy_q[i_alu_rd_addr];
    assign alu_acc     = i_alu_valid && o_alu_ready;

    always_comb begin
        wr_d    = wr_q;
        wr_d.we = 1'b0;
        wr_ld_d = 1'b0;
        unique case (1'b1)
            resp_acc: begin
                wr_d.addr = q_head;
                wr_d.data = i_ld_resp_data;
                wr_d.we   = (q_head != REG_ZERO);
                wr_ld_d   = 1'b1;
            end
            alu_acc: begin
                wr_d.addr = i_alu_rd_addr;
                wr_d.data = i_alu_data;
                wr_d.we   = (i_alu_rd_addr != REG_ZERO);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        set_vec = issue_acc ? reg_onehot(i_ld_rd_addr) : '0;
        clr_vec = (wr_q.we && wr_ld_q) ? reg_onehot(wr_q.addr) : '0;
        busy_d  = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q    <= '0;
            wr_ld_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            wr_ld_q <= wr_ld_d;
            busy_q  <= busy_d;
        end
    end

    assign o_rd_addr = wr_q.addr;
    assign o_rd_we   = wr_q.we;
    assign o_rd_data = wr_q.data;
    assign o_busy    = busy_q;

`ifdef Z16_WB_BYPASS_EN
    assign o_rs1_fwd  = wr_q.we && (wr_q.addr == i_rs1_addr)
                      && (i_rs1_addr != REG_ZERO);
    assign o_rs2_fwd  = wr_q.we && (wr_q.addr == i_rs2_addr)
                      && (i_rs2_addr != REG_ZERO);
    assign o_fwd_data = wr_q.data;
    assign o_rs1_busy = busy_q[i_rs1_addr] && !o_rs1_fwd;
    assign o_rs2_busy = busy_q[i_rs2_addr] && !o_rs2_fwd;
`else
    assign o_rs1_busy = busy_q[i_rs1_addr];
    assign o_rs2_busy = busy_q[i_rs2_addr];
`endif

endmodule

// File: tb/tb_z16_writeback_unit.sv
// Randomized self-checking bench for z16_writeback_unit.
// Reference model: in-flight load list plus a one-deep pending-write slot.
module tb_z16_writeback_unit;

    localparam int LD_DEPTH = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [3:0]  i_alu_rd_addr = '0;
    logic [15:0] i_alu_data = '0;
    logic        o_alu_ready;
    logic        i_ld_issue_valid = 1'b0;
    logic [3:0]  i_ld_rd_addr = '0;
    logic        o_ld_issue_ready;
    logic        i_ld_resp_valid = 1'b0;
    logic [15:0] i_ld_resp_data = '0;
    logic        o_ld_resp_ready;
    logic [3:0]  o_rd_addr;
    logic        o_rd_we;
    logic [15:0] o_rd_data;
    logic [3:0]  i_rs1_addr = '0;
    logic [3:0]  i_rs2_addr = '0;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic [15:0] o_busy;
`ifdef Z16_WB_BYPASS_EN
    logic        o_rs1_fwd;
    logic        o_rs2_fwd;
    logic [15:0] o_fwd_data;
`endif

    always #5 i_clk = ~i_clk;

    z16_writeback_unit #(
        .LD_DEPTH (LD_DEPTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_alu_valid      (i_alu_valid),
        .i_alu_rd_addr    (i_alu_rd_addr),
        .i_alu_data       (i_alu_data),
        .o_alu_ready      (o_alu_ready),
        .i_ld_issue_valid (i_ld_issue_valid),
        .i_ld_rd_addr     (i_ld_rd_addr),
        .o_ld_issue_ready (o_ld_issue_ready),
        .i_ld_resp_valid  (i_ld_resp_valid),
        .i_ld_resp_data   (i_ld_resp_data),
        .o_ld_resp_ready  (o_ld_resp_ready),
        .o_rd_addr        (o_rd_addr),
        .o_rd_we          (o_rd_we),
        .o_rd_data        (o_rd_data),
        .i_rs1_addr       (i_rs1_addr),
        .i_rs2_addr       (i_rs2_addr),
        .o_rs1_busy       (o_rs1_busy),
        .o_rs2_busy       (o_rs2_busy),
        .o_busy           (o_busy)
`ifdef Z16_WB_BYPASS_EN
        ,
        .o_rs1_fwd        (o_rs1_fwd),
        .o_rs2_fwd        (o_rs2_fwd),
        .o_fwd_data       (o_fwd_data)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: loads issued but not yet answered, and the write due now.
    int          ldq[$];
    logic        e_we   = 1'b0;
    logic        e_ld   = 1'b0;
    logic [3:0]  e_addr = '0;
    logic [15:0] e_data = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A register is busy while its load is in flight or its load data is
    // being written this cycle.
    function automatic logic m_busy(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        foreach (ldq[k]) begin
            if (ldq[k] == int'(r)) return 1'b1;
        end
        return e_we && e_ld && (e_addr == r);
    endfunction

    function automatic logic m_fwd(input logic [3:0] r);
`ifdef Z16_WB_BYPASS_EN
        return e_we && (e_addr == r) && (r != 4'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic av, input logic [3:0] aa,
                        input logic [15:0] ad, input logic iv,
                        input logic [3:0] ia, input logic rv,
                        input logic [15:0] rdat, input logic [3:0] r1,
                        input logic [3:0] r2);
        logic        rsp_rdy, iss_rdy, alu_rdy;
        logic        n_we, n_ld;
        logic [3:0]  n_addr;
        logic [15:0] n_data;
        logic [15:0] bvec;
        int          a;
        i_alu_valid      = av;
        i_alu_rd_addr    = aa;
        i_alu_data       = ad;
        i_ld_issue_valid = iv;
        i_ld_rd_addr     = ia;
        i_ld_resp_valid  = rv;
        i_ld_resp_data   = rdat;
        i_rs1_addr       = r1;
        i_rs2_addr       = r2;
        @(negedge i_clk);
        rsp_rdy = (ldq.size() != 0);
        iss_rdy = (ldq.size() < LD_DEPTH) && !m_busy(ia)
                && !(e_we && e_addr == ia);
        alu_rdy = !(rv && rsp_rdy) && !m_busy(aa);
        for (int r = 0; r < 16; r++) bvec[r] = m_busy(4'(r));
        chk("resp_ready", 32'(o_ld_resp_ready), 32'(rsp_rdy));
        chk("issue_ready", 32'(o_ld_issue_ready), 32'(iss_rdy));
        chk("alu_ready", 32'(o_alu_ready), 32'(alu_rdy));
        chk("rd_we", 32'(o_rd_we), 32'(e_we));
        if (e_we) begin
            chk("rd_addr", 32'(o_rd_addr), 32'(e_addr));
            chk("rd_data", 32'(o_rd_data), 32'(e_data));
        end
        chk("busy_vec", 32'(o_busy), 32'(bvec));
        chk("rs1_busy", 32'(o_rs1_busy), 32'(m_busy(r1) && !m_fwd(r1)));
        chk("rs2_busy", 32'(o_rs2_busy), 32'(m_busy(r2) && !m_fwd(r2)));
`ifdef Z16_WB_BYPASS_EN
        chk("rs1_fwd", 32'(o_rs1_fwd), 32'(m_fwd(r1)));
        chk("rs2_fwd", 32'(o_rs2_fwd), 32'(m_fwd(r2)));
        if (e_we) chk("fwd_data", 32'(o_fwd_data), 32'(e_data));
`endif
        n_we   = 1'b0;
        n_ld   = 1'b0;
        n_addr = e_addr;
        n_data = e_data;
        if (rv && rsp_rdy) begin
            a      = ldq.pop_front();
            n_addr = 4'(a);
            n_data = rdat;
            n_we   = (a != 0);
            n_ld   = 1'b1;
        end else if (av && alu_rdy) begin
            n_addr = aa;
            n_data = ad;
            n_we   = (aa != 4'd0);
        end
        if (iv && iss_rdy) ldq.push_back(int'(ia));
        @(posedge i_clk);
        #1;
        e_we   = n_we;
        e_ld   = n_ld;
        e_addr = n_addr;
        e_data = n_data;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        i_alu_valid      = 1'b1;
        i_ld_issue_valid = 1'b1;
        i_ld_resp_valid  = 1'b1;
        i_rst            = 1'b1;
        #1;
        chk("rst_we", 32'(o_rd_we), 32'd0);
        chk("rst_addr", 32'(o_rd_addr), 32'd0);
        chk("rst_data", 32'(o_rd_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_alu_rdy", 32'(o_alu_ready), 32'd0);
        chk("rst_iss_rdy", 32'(o_ld_issue_ready), 32'd0);
        chk("rst_rsp_rdy", 32'(o_ld_resp_ready), 32'd0);
        ldq.delete();
        e_we   = 1'b0;
        e_ld   = 1'b0;
        e_addr = '0;
        e_data = '0;
        @(negedge i_clk);
        i_alu_valid      = 1'b0;
        i_ld_issue_valid = 1'b0;
        i_ld_resp_valid  = 1'b0;
        i_rst            = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [3:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        @(posedge i_clk);
        #1;
        do_reset();

        // ALU write to r3
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0);
        chk("alu_we", 32'(o_rd_we), 32'd1);
        chk("alu_addr", 32'(o_rd_addr), 32'd3);
        chk("alu_data", 32'(o_rd_data), 32'h1234);

        // load to r5, busy through its commit cycle
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0, 16'h0, 4'd5, 4'd0);
        chk("ld5_busy", 32'(o_busy), 32'h0020);
        chk("ld5_rs1", 32'(o_rs1_busy), 32'd1);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'hBEEF, 4'd5, 4'd0);
        chk("ld5_addr", 32'(o_rd_addr), 32'd5);
        chk("ld5_data", 32'(o_rd_data), 32'hBEEF);
        chk("ld5_commit_busy", 32'(o_busy), 32'h0020);
        idle();
        chk("ld5_clear", 32'(o_busy), 32'h0000);

        // response beats ALU
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 16'h0, 4'd0, 4'd0);
        step(1'b1, 4'd2, 16'h5555, 1'b0, 4'd0, 1'b1, 16'hAAAA, 4'd0, 4'd0);
        chk("prio_addr", 32'(o_rd_addr), 32'd7);
        chk("prio_data", 32'(o_rd_data), 32'hAAAA);
        step(1'b1, 4'd2, 16'h5555, 1'b0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0);
        chk("late_alu_addr", 32'(o_rd_addr), 32'd2);
        chk("late_alu_data", 32'(o_rd_data), 32'h5555);

        // full queue, WAW block
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 16'h0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 1'b0, 16'h0, 4'd0, 4'd0);
        chk("two_busy", 32'(o_busy), 32'h0050);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd8, 1'b1, 16'h0001, 4'd0, 4'd0);
        chk("full_refused", 32'(o_busy), 32'h0050);
        chk("r4_addr", 32'(o_rd_addr), 32'd4);
        chk("r4_data", 32'(o_rd_data), 32'h0001);
        step(1'b1, 4'd4, 16'h9999, 1'b0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h0002, 4'd0, 4'd0);
        chk("r6_addr", 32'(o_rd_addr), 32'd6);
        chk("r6_data", 32'(o_rd_data), 32'h0002);
        idle();

        // r0 targets are consumed silently
        step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0);
        chk("r0_alu_we", 32'(o_rd_we), 32'd0);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0);
        chk("r0_ld_busy", 32'(o_busy), 32'h0000);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h1234, 4'd0, 4'd0);
        chk("r0_ld_we", 32'(o_rd_we), 32'd0);
        idle();

        // reset with loads queued
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 1'b0, 16'h0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 1'b0, 16'h0, 4'd0, 4'd0);
        do_reset();
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd11, 1'b1, 16'h7777, 4'd0, 4'd0);
        chk("post_rst_busy", 32'(o_busy), 32'h0800);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h3333, 4'd0, 4'd0);
        chk("post_rst_addr", 32'(o_rd_addr), 32'd11);
        chk("post_rst_data", 32'(o_rd_data), 32'h3333);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), pick_addr(),
                     16'($urandom),
                     1'($urandom_range(0, 2) != 0), pick_addr(),
                     1'($urandom_range(0, 2) != 0), 16'($urandom),
                     pick_addr(), pick_addr());
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
